fetch_pc_controller: RTL
========================

Name: fetch_pc_controller

Overview:
- Sequencer for the fetch/decode stage. Each cycle it selects the next fetch PC from the predicted PC, a resolved jalr/ret target, or a mispredict correction.
- Detects load-use hazards and waits for indirect jumps. Issues the bubble (WB_HICCUP) and RA/EX flush controls the fetch/decode stage consumes.
- Keeps saturating stall/flush performance counters and a sticky protocol-error flag.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
JALR_WAIT_MAX, 8, cycles in JALR_WAIT before protocol_err is set (1..255)
CNT_W, 32, width of each performance counter

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  synchronous, active-high; sampled on posedge clk
predict_pc  in  32  default next PC from predictor
dec_valid  in  1  decoded instruction at current pc is valid (not a bubble)
dec_is_load  in  1  decoded instruction is a load
dec_is_jalr  in  1  decoded instruction is jalr or ret (indirect)
dec_rd  in  5  destination register of decoded instruction
dec_rs1  in  5  source register a of decoded instruction
dec_rs2  in  5  source register b of decoded instruction
jalr_resolve  in  1  indirect target resolved this cycle
jalr_target  in  32  resolved indirect target
mispredict  in  1  branch mispredict detected downstream
correct_pc  in  32  corrected PC for mispredict
pc  out  32  fetch PC (registered)
bubble  out  1  replace current decode output with WB_HICCUP
flush_ra_ex  out  1  one-cycle flush of RA/EX stages
busy  out  1  state != RUN
protocol_err  out  1  sticky error flag
stall_cycles  out  CNT_W  saturating count of cycles with bubble=1
flush_count  out  CNT_W  saturating count of mispredict flushes

Behaviour:
- Reset (synchronous, reset=1 at posedge) has top priority:
  - pc=RESET_PC, bubble=1, flush_ra_ex=0, state=RUN, busy=0, protocol_err=0, counters=0.
  - Hazard history cleared: last_load=0, last_rd=0. Wait counter=0.
  - Reset mid-JALR_WAIT or mid-LOAD_STALL abandons the operation immediately.
- All outputs are registered. Decisions use inputs sampled at posedge and take effect the same edge (1-cycle latency).
- Priority each cycle: mispredict > jalr_resolve (in JALR_WAIT only) > hazard stall > predict_pc.
- States:
  - RUN
    - mispredict: pc<=correct_pc, flush_ra_ex<=1, bubble<=1, stay RUN, clear history.
    - Load-use: dec_valid && last_load && last_rd!=0 && (dec_rs1==last_rd || dec_rs2==last_rd). Hold pc, bubble<=1, goto LOAD_STALL.
    - dec_valid && dec_is_jalr: hold pc, bubble<=1, wait_cnt<=0, goto JALR_WAIT.
    - Otherwise: pc<=predict_pc, bubble<=!dec_valid.
    - History update: when not stalling, last_load<=dec_valid&&dec_is_load and last_rd<=dec_rd.
  - LOAD_STALL (exactly one cycle)
    - pc<=predict_pc, bubble<=0, clear history, goto RUN. The stalled instruction is not re-checked.
    - mispredict overrides: behaves as in RUN and goes to RUN.
  - JALR_WAIT
    - jalr_resolve: pc<=jalr_target, bubble<=1, goto RUN, clear history.
    - Otherwise: hold pc, bubble<=1, wait_cnt increments and saturates at JALR_WAIT_MAX. protocol_err<=1 when wait_cnt reaches JALR_WAIT_MAX; the block keeps waiting.
    - mispredict overrides jalr_resolve in the same cycle: use correct_pc and flush.
- jalr_resolve in RUN or LOAD_STALL is ignored and sets protocol_err.
- flush_ra_ex is high for exactly the cycle following a sampled mispredict. Back-to-back mispredicts give consecutive pulses.
- Counters:
  - stall_cycles increments on each cycle whose registered bubble=1, except the first cycle after reset.
  - flush_count increments per flush pulse.
  - Both saturate at all-ones; no wrap.
- No PC arithmetic in this block; targets pass through unmodified, including misaligned values.

Decomposition:
- Shared package/defines:
  - State encoding ST_RUN/ST_LOAD_STALL/ST_JALR_WAIT (2 bits).
  - WB_HICCUP and other WB_* codes, already shared with the decoder.
  - RESET_PC default.
- One sub-module: sat_counter (param width; inc, clear inputs; saturating). Instantiated twice.

Test Plan:
- Reset then predict_pc=0x4,0x8,… with dec_valid=1 and no hazards -> pc follows predict_pc one cycle later; bubble=0 after the first cycle; stall_cycles=0.
- Load x5, then next instruction rs1=5 -> exactly one cycle with bubble=1 and pc held; stall_cycles=1.
- Load x0, then rs1=0 -> no stall.
- dec_is_jalr at pc=0x20; jalr_resolve after 3 cycles with target 0x100 -> bubble=1 for 4 cycles, then pc=0x100, busy returns to 0, protocol_err=0.
- jalr with no resolve for JALR_WAIT_MAX cycles -> protocol_err=1 and stays 1; a later resolve still redirects pc.
- mispredict with correct_pc=0x40 together with jalr_resolve in JALR_WAIT -> pc=0x40, flush_ra_ex pulses once, flush_count=1.
- reset asserted in JALR_WAIT -> next cycle pc=RESET_PC, state RUN, counters 0.

Source files
------------

// File: rtl/fetch_pc_controller_pkg.sv
// fetch_pc_controller_pkg
// Purpose: shared definitions for the fetch PC sequencer and the decoder it
//   works alongside: FSM state encoding, writeback codes (including the
//   WB_HICCUP bubble code), the default reset PC and the load-use hazard test.
// Ports: none (package).
package fetch_pc_controller_pkg;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_JALR_WAIT  = 2'd2
  } fetch_state_t;

  // Writeback codes shared with the decoder; WB_HICCUP marks a bubble.
  localparam logic [2:0] WB_NONE   = 3'd0;
  localparam logic [2:0] WB_ALU    = 3'd1;
  localparam logic [2:0] WB_MEM    = 3'd2;
  localparam logic [2:0] WB_PC4    = 3'd3;
  localparam logic [2:0] WB_HICCUP = 3'd7;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // x0 is hardwired to zero, so a load targeting it can never create a hazard.
  function automatic logic load_use_hit(
    input logic       last_load,
    input logic [4:0] last_rd,
    input logic [4:0] rs1,
    input logic [4:0] rs2
  );
    return last_load && (last_rd != 5'd0) && ((rs1 == last_rd) || (rs2 == last_rd));
  endfunction

endpackage

// File: rtl/fetch_pc_controller_if.sv
// fetch_pc_controller_if
// Purpose: bundles the decode/redirect inputs and the fetch control/status
//   outputs of fetch_pc_controller.
// Modports:
//   master - the surrounding pipeline: drives predictor, decode and redirect
//            signals; observes pc, bubble, flush, status and counters.
//   slave  - the controller itself.
interface fetch_pc_controller_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      predict_pc;
  logic             dec_valid;
  logic             dec_is_load;
  logic             dec_is_jalr;
  logic [4:0]       dec_rd;
  logic [4:0]       dec_rs1;
  logic [4:0]       dec_rs2;
  logic             jalr_resolve;
  logic [31:0]      jalr_target;
  logic             mispredict;
  logic [31:0]      correct_pc;

  logic [31:0]      pc;
  logic             bubble;
  logic             flush_ra_ex;
  logic             busy;
  logic             protocol_err;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output predict_pc, dec_valid, dec_is_load, dec_is_jalr, dec_rd, dec_rs1, dec_rs2,
           jalr_resolve, jalr_target, mispredict, correct_pc,
    input  pc, bubble, flush_ra_ex, busy, protocol_err, stall_cycles, flush_count
  );

  modport slave (
    input  predict_pc, dec_valid, dec_is_load, dec_is_jalr, dec_rd, dec_rs1, dec_rs2,
           jalr_resolve, jalr_target, mispredict, correct_pc,
    output pc, bubble, flush_ra_ex, busy, protocol_err, stall_cycles, flush_count
  );
endinterface

// File: rtl/fetch_pc_controller_sat_counter.sv
// sat_counter
// Purpose: up-counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk   - clock
//   clear - synchronous clear, dominates inc
//   inc   - count one event this cycle
//   count - current count value
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/fetch_pc_controller.sv
// fetch_pc_controller
// Purpose: picks the next fetch PC each cycle (predicted PC, resolved
//   jalr/ret target or mispredict correction), stalls one cycle on load-use
//   hazards, waits for indirect targets, and emits the bubble / RA-EX flush
//   controls for the fetch/decode stage. Keeps saturating stall and flush
//   counters plus a sticky protocol-error flag.
// Ports:
//   clk   - clock, all state updates on posedge
//   reset - synchronous active-high reset
//   bus   - fetch_pc_controller_if.slave: decode/redirect inputs in,
//           pc/bubble/flush_ra_ex/busy/protocol_err/counters out
module fetch_pc_controller
  import fetch_pc_controller_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = RESET_PC_DEFAULT,
  parameter int          JALR_WAIT_MAX = 8,
  parameter int          CNT_W         = 32
) (
  input logic                  clk,
  input logic                  reset,
  fetch_pc_controller_if.slave bus
);

  localparam logic [7:0] WAIT_MAX = 8'(JALR_WAIT_MAX);

  fetch_state_t state;
  logic [31:0]  pc_q;
  logic         bubble_q;
  logic         flush_q;
  logic         busy_q;
  logic         err_q;
  logic         last_load;
  logic [4:0]   last_rd;
  logic [7:0]   wait_cnt;
  logic         first_after_reset;
  logic         hazard;

  assign hazard = bus.dec_valid &&
                  load_use_hit(last_load, last_rd, bus.dec_rs1, bus.dec_rs2);

  // Main sequencer. Mispredict outranks everything; otherwise each state
  // decides pc/bubble. Outputs are all registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_RUN;
      pc_q      <= RESET_PC;
      bubble_q  <= 1'b1;
      flush_q   <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      last_load <= 1'b0;
      last_rd   <= 5'd0;
      wait_cnt  <= 8'd0;
    end else begin
      flush_q <= 1'b0;

      // A resolve outside JALR_WAIT means nobody asked for it.
      if (bus.jalr_resolve && (state != ST_JALR_WAIT)) begin
        err_q <= 1'b1;
      end

      if (bus.mispredict) begin
        state     <= ST_RUN;
        pc_q      <= bus.correct_pc;
        bubble_q  <= 1'b1;
        flush_q   <= 1'b1;
        busy_q    <= 1'b0;
        last_load <= 1'b0;
        last_rd   <= 5'd0;
      end else begin
        case (state)
          ST_RUN: begin
            if (hazard) begin
              state    <= ST_LOAD_STALL;
              bubble_q <= 1'b1;
              busy_q   <= 1'b1;
            end else if (bus.dec_valid && bus.dec_is_jalr) begin
              state    <= ST_JALR_WAIT;
              bubble_q <= 1'b1;
              busy_q   <= 1'b1;
              wait_cnt <= 8'd0;
            end else begin
              pc_q      <= bus.predict_pc;
              bubble_q  <= !bus.dec_valid;
              busy_q    <= 1'b0;
              last_load <= bus.dec_valid && bus.dec_is_load;
              last_rd   <= bus.dec_rd;
            end
          end

          // The stalled instruction goes through without a second hazard check.
          ST_LOAD_STALL: begin
            state     <= ST_RUN;
            pc_q      <= bus.predict_pc;
            bubble_q  <= 1'b0;
            busy_q    <= 1'b0;
            last_load <= 1'b0;
            last_rd   <= 5'd0;
          end

          // The error flags a suspiciously long wait but the wait continues.
          ST_JALR_WAIT: begin
            bubble_q <= 1'b1;
            if (bus.jalr_resolve) begin
              state     <= ST_RUN;
              pc_q      <= bus.jalr_target;
              busy_q    <= 1'b0;
              last_load <= 1'b0;
              last_rd   <= 5'd0;
            end else if (wait_cnt != WAIT_MAX) begin
              wait_cnt <= wait_cnt + 8'd1;
              if (wait_cnt == (WAIT_MAX - 8'd1)) begin
                err_q <= 1'b1;
              end
            end
          end

          default: begin
            state  <= ST_RUN;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  // The reset bubble itself is not a stall, so the first post-reset cycle
  // is masked from the stall counter.
  always_ff @(posedge clk) begin
    first_after_reset <= reset;
  end

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clear (reset),
    .inc   (bubble_q && !first_after_reset),
    .count (bus.stall_cycles)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clear (reset),
    .inc   (flush_q),
    .count (bus.flush_count)
  );

  assign bus.pc           = pc_q;
  assign bus.bubble       = bubble_q;
  assign bus.flush_ra_ex  = flush_q;
  assign bus.busy         = busy_q;
  assign bus.protocol_err = err_q;

endmodule
